// File: rtl/dff_response_checker.sv
// Online checker for a single enabled, synchronously-reset flip-flop: mirrors the
// flop in a reference model and compares its output one cycle later.
`timescale 1ns/1ps

module dff_response_checker #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CHK_W       = 16,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             dut_rst,
    input  logic             en,
    input  logic             d,
    input  logic             q,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CHK_W-1:0] check_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q;
    logic   exp_q;
    logic   exp_next;
    logic   mismatch;

    // Next value of the reference flop: reset dominates enable.
    always_comb begin
        exp_next = exp_q;
        if (!dut_rst) begin
            exp_next = 1'b0;
        end else if (en) begin
            exp_next = d;
        end
    end

    // exp_q still holds the value predicted at the previous edge.
    assign mismatch = (q != exp_q);
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            exp_q        <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            mismatch_cnt <= '0;
            check_cnt    <= '0;
        end else if (clear) begin
            state_q      <= IDLE;
            exp_q        <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            mismatch_cnt <= '0;
            check_cnt    <= '0;
        end else begin
            err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARMED;
                    end
                end
                // Wait for the observed flop to be reset so both sides start at 0.
                ARMED: begin
                    exp_q <= exp_next;
                    if (!dut_rst) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    exp_q <= exp_next;
                    if (!(&check_cnt)) begin
                        check_cnt <= check_cnt + CHK_W'(1);
                    end
                    if (mismatch) begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        if (!(&mismatch_cnt)) begin
                            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        end
                        if (STOP_ON_ERR != 0) begin
                            state_q <= HALT;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dff_response_checker.md
DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8; width of the mismatch counter.
REQ-002 SHALL have parameter CHK_W, default 16; width of the checked-cycle counter.
REQ-003 SHALL have parameter STOP_ON_ERR, default 0; 1 = halt checking on the first mismatch.
REQ-004 SHALL have port clk  input  1  checker clock, the same clock that drives the observed flip-flop; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  checker reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  level-sampled request to arm checking.
REQ-007 SHALL have port clear  input  1  synchronous return to IDLE with counters zeroed.
REQ-008 SHALL have port dut_rst  input  1  observed synchronous active-low reset of the flip-flop under check.
REQ-009 SHALL have port en  input  1  observed flip-flop enable.
REQ-010 SHALL have port d  input  1  observed flip-flop data input.
REQ-011 SHALL have port q  input  1  observed flip-flop output.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a mismatch.
REQ-013 SHALL have port err_sticky  output  1  set by any mismatch, cleared only by clear or rst.
REQ-014 SHALL have port mismatch_cnt  output  CNT_W  saturating mismatch count.
REQ-015 SHALL have port check_cnt  output  CHK_W  saturating count of compared cycles.
REQ-016 SHALL have port state  output  2  encoded FSM state (IDLE=0, ARMED=1, CHECK=2, HALT=3).

Function
REQ-017 SHALL keep a reference model exp_q updated at each rising edge outside IDLE: dut_rst=0 -> 0; else en=1 -> d; else hold.
REQ-018 SHALL sample q at edge N and compare it against the exp_q value produced at edge N-1, giving one cycle of compare latency.
REQ-019 SHALL, in IDLE, ignore dut_rst/en/d/q and go to ARMED at the edge where start=1.
REQ-020 SHALL, in ARMED, perform no comparison and go to CHECK at the first edge that samples dut_rst=0; exp_q becomes 0 at that edge.
REQ-021 SHALL, in CHECK, compare on every edge: equal -> check_cnt+1; unequal -> check_cnt+1, mismatch_cnt+1, err=1 for that cycle, err_sticky=1.
REQ-022 SHALL, with STOP_ON_ERR=1, go from CHECK to HALT on the mismatch edge; HALT freezes the counters and exp_q, and err stays 0 there.
REQ-023 SHALL, with STOP_ON_ERR=0, stay in CHECK after mismatches.
REQ-024 SHALL saturate both counters at all-ones, with no wrap to zero.
REQ-025 SHALL, when clear=1 at an edge in any state, go to IDLE and zero err, err_sticky, both counters and exp_q.
REQ-026 SHALL, when clear and start are both 1, let clear win.
REQ-027 SHALL ignore start in ARMED, CHECK and HALT.
REQ-028 SHALL, on the first CHECK-state compare, use the exp_q set at the ARMED->CHECK edge (0).
REQ-029 SHALL, in CHECK, treat dut_rst=0 as a normal model update (exp_q=0); the comparison of that edge still runs.

Reset
REQ-030 SHALL, while rst=0, immediately (asynchronously) force state=IDLE, err=0, err_sticky=0, mismatch_cnt=0, check_cnt=0, exp_q=0.
REQ-031 SHALL, on rst assertion mid-CHECK, abandon the run; no comparison is reported for the edge at which rst rises.
REQ-032 SHALL resume clocked operation on the first rising edge after rst deasserts.

Verification
REQ-033 SHALL be covered by: correct flip-flop model driven by d toggling every 3.5 ns, en=0 for 20 ns then 1, dut_rst=0 for 10 ns, start=1 at t=2 -> state reaches CHECK, err never 1, mismatch_cnt=0, check_cnt equals the number of CHECK edges.
REQ-034 SHALL be covered by: a fault that forces q=1 for one cycle with expected 0 -> err pulses exactly one cycle later, mismatch_cnt=1, err_sticky=1 and stays 1.
REQ-035 SHALL be covered by: STOP_ON_ERR=1 with two consecutive faults -> mismatch_cnt=1, state=3, counters frozen until clear.
REQ-036 SHALL be covered by: CNT_W=2 with a permanently inverted q -> mismatch_cnt sticks at 3.
REQ-037 SHALL be covered by: start=1 and clear=1 in the same cycle from IDLE -> state stays 0; then rst=0 asynchronously mid-CHECK -> all outputs 0 before the next edge.
REQ-038 SHALL be covered by: start with dut_rst held 1 for 20 cycles -> state=1, check_cnt=0 until the first dut_rst=0 edge.
